// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller for the 5-stage core: drives en/clr of every pipeline
// register, sequences the iterative divider and counts stall cycles.
module pipe_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             ex_div_start,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             exc_valid,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_clr,
    output logic             de_en,
    output logic             de_clr,
    output logic             em_en,
    output logic             em_clr,
    output logic             mw_en,
    output logic             mw_clr,
    output logic             div_done,
    output logic             redirect_hold,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, DIV} state_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    state_t           state_q, state_d;
    logic [5:0]       divCnt_q, divCnt_d;
    logic             brPend_q, brPend_d;
    logic [CNT_W-1:0] stallCnt_q;
    logic             loadUse, divBusy, divLast, branch;

    assign loadUse = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    assign divLast = (state_q == DIV) && (divCnt_q == 6'd0);
    // The start cycle already freezes the front end, so busy covers it too.
    assign divBusy = ((state_q == RUN) && ex_div_start) || ((state_q == DIV) && (divCnt_q != 6'd0));
    assign branch  = ex_br_taken || brPend_q;

    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        fd_clr   = 1'b0;
        de_en    = 1'b1;
        de_clr   = 1'b0;
        em_en    = 1'b1;
        em_clr   = 1'b0;
        mw_en    = 1'b1;
        mw_clr   = 1'b0;
        div_done = 1'b0;
        state_d  = state_q;
        divCnt_d = divCnt_q;
        brPend_d = brPend_q;
        if (rst) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            de_en  = 1'b0;
            em_en  = 1'b0;
            mw_en  = 1'b0;
            fd_clr = 1'b1;
            de_clr = 1'b1;
            em_clr = 1'b1;
            mw_clr = 1'b1;
        end else if (exc_valid) begin
            fd_clr   = 1'b1;
            de_clr   = 1'b1;
            em_clr   = 1'b1;
            mw_clr   = 1'b1;
            state_d  = RUN;
            brPend_d = 1'b0;
        end else if (dmem_busy || divBusy) begin
            // Freeze everything up to EX/MEM and bubble MEM/WB so WB never commits twice.
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            de_en  = 1'b0;
            em_en  = 1'b0;
            mw_clr = 1'b1;
            if (!dmem_busy) begin
                if (state_q == RUN) begin
                    state_d  = DIV;
                    divCnt_d = DIV_LOAD;
                end else begin
                    divCnt_d = divCnt_q - 6'd1;
                end
            end
        end else begin
            if (divLast) begin
                div_done = 1'b1;
                state_d  = RUN;
            end
            if (branch) begin
                fd_clr   = 1'b1;
                de_clr   = 1'b1;
                pc_en    = !imem_busy;
                brPend_d = imem_busy;
            end else if (imem_busy || loadUse) begin
                pc_en  = 1'b0;
                fd_en  = 1'b0;
                de_clr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            divCnt_q   <= 6'd0;
            brPend_q   <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            divCnt_q <= divCnt_d;
            brPend_q <= brPend_d;
            if (!pc_en) begin
                stallCnt_q <= stallCnt_q + 1'b1;
            end
        end
    end

    assign redirect_hold = brPend_q;
    assign stall_cycles  = stallCnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: fixed vector table, hand-written multi-cycle
// sequences, then random stimulus against a cycle-age reference model.
module tb_pipe_ctrl;

    localparam int DIVC = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
    logic        id_use_rs = 0, id_use_rt = 0, ex_mem_read = 0, ex_br_taken = 0;
    logic        ex_div_start = 0, imem_busy = 0, dmem_busy = 0, exc_valid = 0;
    logic        pc_en, fd_en, fd_clr, de_en, de_clr, em_en, em_clr, mw_en, mw_clr;
    logic        div_done, redirect_hold;
    logic [31:0] stall_cycles;
    logic [9:0]  dutVec;

    int checks = 0;
    int failures = 0;

    // Reference state: age of the running division (0 = idle), pending redirect, stall count.
    int          mDivAge = 0;
    logic        mBrPend = 1'b0;
    logic [31:0] mStall = '0;

    localparam logic [9:0] V_RST  = 10'b0010101010;
    localparam logic [9:0] V_IDLE = 10'b1101010100;
    localparam logic [9:0] V_HOLD = 10'b0001110100;
    localparam logic [9:0] V_BR   = 10'b1111110100;
    localparam logic [9:0] V_EXC  = 10'b1111111110;
    localparam logic [9:0] V_FRZ  = 10'b0000000110;

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       useRs, useRt, memRead, br, imem, dmem, exc;
        logic [9:0] expVec;
    } vec_t;

    pipe_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_br_taken(ex_br_taken), .ex_div_start(ex_div_start), .imem_busy(imem_busy),
        .dmem_busy(dmem_busy), .exc_valid(exc_valid), .pc_en(pc_en), .fd_en(fd_en),
        .fd_clr(fd_clr), .de_en(de_en), .de_clr(de_clr), .em_en(em_en), .em_clr(em_clr),
        .mw_en(mw_en), .mw_clr(mw_clr), .div_done(div_done), .redirect_hold(redirect_hold),
        .stall_cycles(stall_cycles)
    );

    assign dutVec = {pc_en, fd_en, fd_clr, de_en, de_clr, em_en, em_clr, mw_en, mw_clr, div_done};

    always #5 clk = ~clk;

    function automatic logic modelLoadUse();
        return ex_mem_read && ex_rd != 0 &&
               ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    endfunction

    function automatic logic modelDivBusy();
        return (mDivAge == 0 && ex_div_start) || (mDivAge != 0 && mDivAge != DIVC - 1);
    endfunction

    // Expected output vector from the priority list applied to the current inputs.
    function automatic logic [9:0] modelOut();
        logic dd;
        dd = (mDivAge == DIVC - 1);
        if (rst) return V_RST;
        if (exc_valid) return V_EXC;
        if (dmem_busy || modelDivBusy()) return V_FRZ;
        if (ex_br_taken || mBrPend) return {!imem_busy, V_BR[8:1], dd};
        if (imem_busy || modelLoadUse()) return {V_HOLD[9:1], dd};
        return {V_IDLE[9:1], dd};
    endfunction

    // Advance the reference model on every clock edge, in every test phase.
    always @(posedge clk) begin
        logic [9:0] e;
        e = modelOut();
        if (rst) begin
            mDivAge <= 0;
            mBrPend <= 1'b0;
            mStall  <= '0;
        end else begin
            mStall <= mStall + (e[9] ? 32'd0 : 32'd1);
            if (exc_valid) begin
                mDivAge <= 0;
                mBrPend <= 1'b0;
            end else if (!dmem_busy) begin
                if (modelDivBusy()) mDivAge <= mDivAge + 1;
                else begin
                    if (mDivAge == DIVC - 1) mDivAge <= 0;
                    if (ex_br_taken || mBrPend) mBrPend <= imem_busy;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearInputs();
        id_rs = 0; id_rt = 0; ex_rd = 0; id_use_rs = 0; id_use_rt = 0;
        ex_mem_read = 0; ex_br_taken = 0; ex_div_start = 0;
        imem_busy = 0; dmem_busy = 0; exc_valid = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; ex_rd = v.rd;
        id_use_rs = v.useRs; id_use_rt = v.useRt; ex_mem_read = v.memRead;
        ex_br_taken = v.br; imem_busy = v.imem; dmem_busy = v.dmem; exc_valid = v.exc;
        ex_div_start = 0; rst = 0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1;
        clearInputs();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    function automatic vec_t mk(input logic [4:0] rs, rt, rd, input logic useRs, useRt, memRead,
                                br, imem, dmem, exc, input logic [9:0] e);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rd = rd; v.useRs = useRs; v.useRt = useRt;
        v.memRead = memRead; v.br = br; v.imem = imem; v.dmem = dmem; v.exc = exc;
        v.expVec = e;
        return v;
    endfunction

    initial begin
        vec_t vecs[14];
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_IDLE);
        vecs[1]  = mk(5, 0, 5, 1, 0, 1, 0, 0, 0, 0, V_HOLD);
        vecs[2]  = mk(1, 7, 7, 0, 1, 1, 0, 0, 0, 0, V_HOLD);
        vecs[3]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, V_IDLE);
        vecs[4]  = mk(5, 3, 5, 0, 1, 1, 0, 0, 0, 0, V_IDLE);
        vecs[5]  = mk(5, 5, 5, 1, 1, 0, 0, 0, 0, 0, V_IDLE);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, V_HOLD);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, V_BR);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, V_EXC);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, V_FRZ);
        vecs[10] = mk(5, 0, 5, 1, 0, 1, 0, 0, 1, 0, V_FRZ);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, V_EXC);
        vecs[12] = mk(5, 0, 5, 1, 0, 1, 1, 0, 0, 0, V_BR);
        vecs[13] = mk(9, 0, 9, 1, 0, 1, 0, 1, 0, 0, V_HOLD);

        // Reset state
        clearInputs();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_vec", 32'(dutVec), 32'(V_RST));
        checkOutput("reset_stall", stall_cycles, 32'd0);
        checkOutput("reset_hold", 32'(redirect_hold), 32'd0);
        rst = 0;

        // Single-cycle vectors from an idle pipeline
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("table_%0d", i), 32'(dutVec), 32'(vecs[i].expVec));
            checkOutput($sformatf("table_hold_%0d", i), 32'(redirect_hold), 32'd0);
        end

        // Full divide: 31 stall cycles then a single div_done pulse
        resetDut();
        for (int k = 1; k <= DIVC; k++) begin
            @(negedge clk);
            ex_div_start = 1;
            #1;
            checkOutput($sformatf("div_pc_en_%0d", k), 32'(pc_en), (k < DIVC) ? 32'd0 : 32'd1);
            checkOutput($sformatf("div_done_%0d", k), 32'(div_done), (k == DIVC) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        ex_div_start = 0;
        #1;
        checkOutput("div_stall_count", stall_cycles, 32'(DIVC - 1));
        checkOutput("div_after_vec", 32'(dutVec), 32'(V_IDLE));

        // Branch resolved while a fetch is outstanding
        resetDut();
        @(negedge clk);
        ex_br_taken = 1; imem_busy = 1;
        #1;
        checkOutput("br1_vec", 32'(dutVec), 32'(V_BR & 10'b0111111111));
        checkOutput("br1_hold", 32'(redirect_hold), 32'd0);
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            ex_br_taken = 0; imem_busy = 1;
            #1;
            checkOutput($sformatf("br%0d_vec", k), 32'(dutVec), 32'(V_BR & 10'b0111111111));
            checkOutput($sformatf("br%0d_hold", k), 32'(redirect_hold), 32'd1);
        end
        @(negedge clk);
        imem_busy = 0;
        #1;
        checkOutput("br4_vec", 32'(dutVec), 32'(V_BR));
        checkOutput("br4_hold", 32'(redirect_hold), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("br5_vec", 32'(dutVec), 32'(V_IDLE));
        checkOutput("br5_hold", 32'(redirect_hold), 32'd0);

        // Exception during a divide aborts it
        resetDut();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            ex_div_start = 1;
            #1;
            checkOutput($sformatf("excdiv_pc_%0d", k), 32'(pc_en), 32'd0);
        end
        @(negedge clk);
        exc_valid = 1;
        #1;
        checkOutput("excdiv_vec", 32'(dutVec), 32'(V_EXC));
        for (int k = 0; k < DIVC; k++) begin
            @(negedge clk);
            exc_valid = 0; ex_div_start = 0;
            #1;
            checkOutput($sformatf("excdiv_after_%0d", k), 32'(dutVec), 32'(V_IDLE));
        end

        // Reset while dividing and waiting on dmem
        resetDut();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            ex_div_start = 1;
        end
        @(negedge clk);
        rst = 1; dmem_busy = 1;
        #1;
        checkOutput("rstdiv_vec", 32'(dutVec), 32'(V_RST));
        @(negedge clk);
        rst = 0; dmem_busy = 0; ex_div_start = 0;
        #1;
        checkOutput("rstdiv_after_vec", 32'(dutVec), 32'(V_IDLE));
        checkOutput("rstdiv_stall", stall_cycles, 32'd0);
        for (int k = 0; k < DIVC; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("rstdiv_nodone_%0d", k), 32'(div_done), 32'd0);
        end

        // Random stimulus against the reference model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst          = ($urandom_range(199) == 0);
            id_rs        = 5'($urandom_range(3));
            id_rt        = 5'($urandom_range(3));
            ex_rd        = 5'($urandom_range(3));
            id_use_rs    = 1'($urandom_range(1));
            id_use_rt    = 1'($urandom_range(1));
            ex_mem_read  = ($urandom_range(2) == 0);
            ex_br_taken  = ($urandom_range(7) == 0);
            imem_busy    = ($urandom_range(3) == 0);
            dmem_busy    = ($urandom_range(7) == 0);
            exc_valid    = ($urandom_range(39) == 0);
            ex_div_start = (mDivAge != 0) ? 1'b1 : ($urandom_range(11) == 0);
            #1;
            checkOutput("rand_vec", 32'(dutVec), 32'(modelOut()));
            checkOutput("rand_hold", 32'(redirect_hold), 32'(mBrPend));
            checkOutput("rand_stall", stall_cycles, mStall);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
